// File: rtl/lieat_ifq_pkg.sv
// Shared types for the instruction fetch queue: the layout of one buffered entry.
// XLEN normally arrives from the shared defines; a 32-bit default keeps this slice standalone.
`ifndef XLEN
`define XLEN 32
`endif

package lieat_ifq_pkg;

  localparam int IFQ_ENTRY_W = 2 * `XLEN + 1;

  typedef struct packed {
    logic [`XLEN-1:0] pc;
    logic [`XLEN-1:0] inst;
    logic             prdt_taken;
  } ifq_entry_t;

endpackage

// File: rtl/lieat_ifq_ram.sv
// DEPTH x W register array: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; only the queue pointers decide what is valid.
module lieat_ifq_ram #(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH),
  parameter int W     = 65
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lieat_ifq.sv
// Instruction fetch queue: DEPTH-entry circular buffer of {pc, inst, prdt_taken}
// between fetch and decode, with a single-cycle flush of all buffered entries.
module lieat_ifq
  import lieat_ifq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [`XLEN-1:0]  in_pc,
  input  logic [`XLEN-1:0]  in_inst,
  input  logic              in_prdt_taken,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [`XLEN-1:0]  out_pc,
  output logic [`XLEN-1:0]  out_inst,
  output logic              out_prdt_taken,
  input  logic              flush,
  output logic              ifq_empty,
  output logic [AW:0]       ifq_count
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Handshakes: a transfer happens on a clock edge where valid and ready are both 1.
  // valid never waits on ready; in_ready and out_valid depend only on the pointers.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic        clear;

  ifq_entry_t  wr_entry;
  ifq_entry_t  rd_entry;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Reset and flush both discard the whole queue and override any handshake.
  assign clear = rst | flush;
  assign push  = in_valid & in_ready & ~clear;
  assign pop   = out_valid & out_ready & ~clear;

  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign ifq_empty = empty;
  assign ifq_count = wr_ptr - rd_ptr;

  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      rd_ptr <= '0;
    end else if (pop) begin
      rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  assign wr_entry.pc         = in_pc;
  assign wr_entry.inst       = in_inst;
  assign wr_entry.prdt_taken = in_prdt_taken;

  lieat_ifq_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (IFQ_ENTRY_W)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wr_entry),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_entry)
  );

  assign out_pc         = rd_entry.pc;
  assign out_inst       = rd_entry.inst;
  assign out_prdt_taken = rd_entry.prdt_taken;

endmodule

// File: tb/tb_lieat_ifq.sv
// Self-checking bench for lieat_ifq: directed scenarios plus random traffic,
// checked every cycle against a queue-based reference model.
`ifndef XLEN
`define XLEN 32
`endif

module tb_lieat_ifq;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [`XLEN-1:0]  in_pc;
  logic [`XLEN-1:0]  in_inst;
  logic              in_prdt_taken;
  logic              out_valid;
  logic              out_ready;
  logic [`XLEN-1:0]  out_pc;
  logic [`XLEN-1:0]  out_inst;
  logic              out_prdt_taken;
  logic              flush;
  logic              ifq_empty;
  logic [AW:0]       ifq_count;

  lieat_ifq #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_pc          (in_pc),
    .in_inst        (in_inst),
    .in_prdt_taken  (in_prdt_taken),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .out_prdt_taken (out_prdt_taken),
    .flush          (flush),
    .ifq_empty      (ifq_empty),
    .ifq_count      (ifq_count)
  );

  // scoreboard: each element is {pc, inst, prdt_taken}
  logic [2*`XLEN:0] exp_q[$];
  int tests_run = 0;
  int fail_count = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      fail_count++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // driver: apply one cycle of inputs, check outputs against the model, advance the model
  task automatic cycle(input logic r, input logic v, input logic [`XLEN-1:0] pc,
                       input logic [`XLEN-1:0] inst, input logic pt,
                       input logic rdy, input logic fl);
    logic [2*`XLEN:0] head;
    bit do_push;
    bit do_pop;
    rst           = r;
    in_valid      = v;
    in_pc         = pc;
    in_inst       = inst;
    in_prdt_taken = pt;
    out_ready     = rdy;
    flush         = fl;
    #1;
    check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    check("in_ready",  64'(in_ready),  64'(exp_q.size() < DEPTH));
    check("ifq_empty", 64'(ifq_empty), 64'(exp_q.size() == 0));
    check("ifq_count", 64'(ifq_count), 64'(exp_q.size()));
    if (exp_q.size() != 0) begin
      head = exp_q[0];
      check("out_pc",         64'(out_pc),         64'(head[2*`XLEN:`XLEN+1]));
      check("out_inst",       64'(out_inst),       64'(head[`XLEN:1]));
      check("out_prdt_taken", 64'(out_prdt_taken), 64'(head[0]));
    end
    do_pop  = (exp_q.size() != 0) && rdy;
    do_push = v && (exp_q.size() < DEPTH);
    @(posedge clk);
    if (r || fl) begin
      exp_q.delete();
    end else begin
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back({pc, inst, pt});
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 1'b0, '0, '0, 1'b0, rdy, 1'b0);
  endtask

  task automatic push(input logic [`XLEN-1:0] pc, input logic [`XLEN-1:0] inst,
                      input logic pt, input logic rdy);
    cycle(1'b0, 1'b1, pc, inst, pt, rdy, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_inst = '0; in_prdt_taken = 1'b0;
    out_ready = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // reset then idle
    for (int i = 0; i < 2; i++) idle(1'b0);

    // fill with decode stalled, observe full, then drain in order
    for (int k = 0; k < 4; k++) push(32'h8000_0000 + 4 * k, 32'h0000_0013 + k, 1'b0, 1'b0);
    idle(1'b0);
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_count", 64'(ifq_count), 64'd4);
    drain();

    // streaming, pointers wrap several times
    for (int k = 0; k < 20; k++) push(32'h8000_0100 + 4 * k, 32'h0000_1000 + k, k[0], 1'b1);
    drain();

    // full plus single pop, then a push lands behind the rest
    for (int k = 0; k < 4; k++) push(32'h8000_0200 + 4 * k, 32'h0000_2000 + k, 1'b0, 1'b0);
    push(32'h8000_0FF0, 32'hDEAD_BEEF, 1'b1, 1'b1);
    push(32'h8000_0210, 32'h0000_2004, 1'b1, 1'b0);
    idle(1'b0);
    drain();

    // flush collides with a push and a pop
    for (int k = 0; k < 3; k++) push(32'h8000_0300 + 4 * k, 32'h0000_3000 + k, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'h8000_1000, 32'h0000_0BAD, 1'b1, 1'b1, 1'b1);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    push(32'h8000_2000, 32'h0000_4000, 1'b0, 1'b0);
    check("post_flush_pc", 64'(out_pc), 64'h8000_2000);
    drain();

    // prediction bit alignment across a wrap
    for (int k = 0; k < 10; k++) push(32'h8000_0400 + 4 * k, 32'h0000_5000 + k, ~k[0], k[1]);
    drain();

    // reset mid-operation with a push pending
    for (int k = 0; k < 2; k++) push(32'h8000_0500 + 4 * k, 32'h0000_6000 + k, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 32'h8000_0600, 32'h0000_7000, 1'b1, 1'b1, 1'b0);
    check("rst_mid_count", 64'(ifq_count), 64'd0);
    idle(1'b0);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      cycle(($urandom_range(0, 63) == 0),
            1'($urandom_range(0, 1)),
            $urandom, $urandom, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 2) != 0),
            ($urandom_range(0, 15) == 0));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
